// File: rtl/swap_sequencer.sv
// Swap sequencer: applies a programmable list of bit-pair swaps to a data word, in forward or reverse order.
// Optional macro SWAP_PAIR_CHECK_EN rejects table writes with bit indices >= WIDTH and raises sticky cfg_err.
module swap_sequencer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned IDXW = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1,
  localparam int unsigned AW   = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [IDXW-1:0]  cfg_pos1,
  input  logic [IDXW-1:0]  cfg_pos2,
  input  logic             cfg_len_we,
  input  logic [AW:0]      cfg_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             cfg_err
);
  localparam logic [IDXW:0] WLIM = (IDXW+1)'(WIDTH);
  localparam logic [AW:0]   DLIM = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE  = (AW+1)'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             cfg_err_q, cfg_err_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic             mode_q, mode_d;
  logic [AW:0]      jlen_q, jlen_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [AW:0]      len_q, len_d;
  logic [IDXW-1:0]  tab1_q [DEPTH];
  logic [IDXW-1:0]  tab1_d [DEPTH];
  logic [IDXW-1:0]  tab2_q [DEPTH];
  logic [IDXW-1:0]  tab2_d [DEPTH];
  logic [IDXW-1:0]  job1_q [DEPTH];
  logic [IDXW-1:0]  job1_d [DEPTH];
  logic [IDXW-1:0]  job2_q [DEPTH];
  logic [IDXW-1:0]  job2_d [DEPTH];

  logic [AW-1:0]    idx_c;
  logic [IDXW-1:0]  p1_c, p2_c;
  logic [WIDTH-1:0] swapped_c;
  logic             last_c;
  logic             addr_ok_c;

  // State and registered handshake/status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = (len_q != '0) ? RUN : DONE;
      RUN:     if (last_c) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // Current entry: forward walks 0..L-1, reverse walks L-1..0
  always_comb begin
    idx_c     = AW'(mode_q ? (jlen_q - cnt_q - ONE) : cnt_q);
    p1_c      = job1_q[idx_c];
    p2_c      = job2_q[idx_c];
    last_c    = (cnt_q == jlen_q - ONE);
    addr_ok_c = ({1'b0, cfg_addr} < DLIM);
    swapped_c = work_q;
    if (({1'b0, p1_c} < WLIM) && ({1'b0, p2_c} < WLIM)) begin
      swapped_c[p1_c] = work_q[p2_c];
      swapped_c[p2_c] = work_q[p1_c];
    end
  end

  // Job snapshot (data, mode, length, table copy) on accept; config writes only while idle
  always_comb begin
    work_d    = work_q;
    mode_d    = mode_q;
    jlen_d    = jlen_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    cfg_err_d = cfg_err_q;
    tab1_d    = tab1_q;
    tab2_d    = tab2_q;
    job1_d    = job1_q;
    job2_d    = job2_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d = in_data;
          mode_d = in_mode;
          jlen_d = len_q;
          cnt_d  = '0;
          job1_d = tab1_q;
          job2_d = tab2_q;
        end
        if (cfg_len_we) len_d = (cfg_len > DLIM) ? DLIM : cfg_len;
`ifdef SWAP_PAIR_CHECK_EN
        if (cfg_we) begin
          if (({1'b0, cfg_pos1} < WLIM) && ({1'b0, cfg_pos2} < WLIM)) begin
            if (addr_ok_c) begin
              tab1_d[cfg_addr] = cfg_pos1;
              tab2_d[cfg_addr] = cfg_pos2;
            end
          end else begin
            cfg_err_d = 1'b1;
          end
        end
`else
        if (cfg_we && addr_ok_c) begin
          tab1_d[cfg_addr] = cfg_pos1;
          tab2_d[cfg_addr] = cfg_pos2;
        end
`endif
      end
      RUN: begin
        work_d = swapped_c;
        cnt_d  = cnt_q + ONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q    <= '0;
      mode_q    <= 1'b0;
      jlen_q    <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      cfg_err_q <= 1'b0;
      tab1_q    <= '{default: '0};
      tab2_q    <= '{default: '0};
      job1_q    <= '{default: '0};
      job2_q    <= '{default: '0};
    end else begin
      work_q    <= work_d;
      mode_q    <= mode_d;
      jlen_q    <= jlen_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      cfg_err_q <= cfg_err_d;
      tab1_q    <= tab1_d;
      tab2_q    <= tab2_d;
      job1_q    <= job1_d;
      job2_q    <= job2_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign cfg_err   = cfg_err_q;
  assign out_data  = work_q;

endmodule

// File: doc/swap_sequencer.md
SWAP_SEQUENCER -- requirements
Module: swap_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits (2..64).
REQ-002 SHALL have parameter DEPTH, default 8: number of entries in the swap-pair table (1..32).
REQ-003 SHALL derive IDXW = clog2(WIDTH) and AW = clog2(DEPTH), each with a minimum of 1.
REQ-004 SHALL have ports:
- clk input 1: sole clock, rising edge.
- rst_n input 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have table-write ports:
- cfg_we input 1: table entry write strobe.
- cfg_addr input AW: table entry index.
- cfg_pos1 input IDXW: first bit index of the pair.
- cfg_pos2 input IDXW: second bit index of the pair.
REQ-006 SHALL have length-write ports:
- cfg_len_we input 1: swap-count write strobe.
- cfg_len input AW+1: number of swaps to apply.
REQ-007 SHALL have input handshake ports:
- in_valid input 1.
- in_ready output 1.
- in_data input WIDTH.
- in_mode input 1: 0 = forward order, 1 = reverse order.
REQ-008 SHALL have output handshake ports:
- out_valid output 1.
- out_ready input 1.
- out_data output WIDTH.
REQ-009 SHALL have status ports:
- busy output 1: high in RUN or DONE.
- cfg_err output 1: sticky configuration error flag.

Function
REQ-010 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-011 In IDLE, in_ready SHALL be 1; in all other states in_ready SHALL be 0.
REQ-012 On in_valid&&in_ready at a clock edge, the block SHALL capture the following and move to the next state:
- Captured: in_data into the work register, in_mode, and a snapshot of the current length L.
- Next state: RUN if L>0, otherwise DONE.
REQ-013 In RUN, each cycle SHALL apply exactly one table entry: work[pos1] and work[pos2] exchange values, all other bits are unchanged.
REQ-014 Forward mode SHALL apply entries 0,1,...,L-1; reverse mode SHALL apply entries L-1,...,0.
REQ-015 After the last entry is applied, the FSM SHALL enter DONE.
REQ-016 Latency SHALL be L+1 clock edges from the accept edge to out_valid=1.
REQ-017 In DONE, the outputs SHALL behave as follows:
- out_valid SHALL be 1 and out_data SHALL equal the work register.
- Both SHALL hold stable while out_ready=0.
- On out_ready=1, the FSM SHALL return to IDLE.
REQ-018 out_valid SHALL be 0 in IDLE and RUN.
REQ-019 A pair with pos1==pos2 SHALL leave the data unchanged and still consume one cycle.
REQ-020 Writes on cfg_we and cfg_len_we SHALL take effect only in IDLE; outside IDLE they SHALL be silently ignored.
REQ-021 A cfg_len write greater than DEPTH SHALL saturate to DEPTH.
REQ-022 If cfg_we and an input accept occur on the same edge, the accepted job SHALL use the pre-write table.
- The write SHALL still commit, because the FSM is in IDLE at that edge.
REQ-023 Forward followed by reverse with the same table SHALL be the identity, since each swap is an involution.

Reset
REQ-024 rst_n=0 SHALL asynchronously force the following, including mid-RUN and mid-DONE, with any in-flight job discarded:
- FSM state: IDLE.
- Registers: work register 0, L=0, length register 0.
- All table entries: (0,0).
- Outputs: out_valid=0, busy=0, cfg_err=0, in_ready=1 after reset release.

Configuration
REQ-025 With macro SWAP_PAIR_CHECK_EN defined, the block SHALL check each cfg_we write:
- A write with cfg_pos1>=WIDTH or cfg_pos2>=WIDTH SHALL be rejected, leaving the entry unchanged.
- A rejected write SHALL set cfg_err=1, which stays set until reset.
REQ-026 Without SWAP_PAIR_CHECK_EN, all writes SHALL be stored unchecked and cfg_err SHALL be tied 0.
- At execution, an entry with an index >=WIDTH SHALL act as a no-op swap.

Verification
REQ-027 Length-1 forward swap SHALL produce the expected result with latency 2. WIDTH=8, entry0=(7,0), len=1, in_data=0x33, mode 0 -> out_data=0xB2 two edges after accept.
REQ-028 Forward and reverse ordering SHALL give distinct results and round-trip to identity. entries (1,0),(2,1), len=2:
- forward of 0x01 -> 0x04.
- reverse of 0x01 -> 0x02.
- reverse of 0x04 -> 0x01.
REQ-029 Zero-length passthrough and backpressure SHALL behave as specified. len=0, in_data=0x5A -> out_valid=1 one edge after accept, data 0x5A. Hold out_ready=0 for 5 cycles -> out_valid and out_data stable, in_ready=0.
REQ-030 Reset mid-RUN SHALL abort the job immediately. len=8, assert rst_n=0 at cycle 3 of RUN -> out_valid=0, busy=0, in_ready=1 after release, and all table entries read as no-op (a new len=1 job passes data unchanged).
REQ-031 Configuration writes outside IDLE SHALL be ignored. cfg_we to entry0=(3,4) during RUN -> the next job uses the old entry0.
REQ-032 Pair checking SHALL reject out-of-range writes. With SWAP_PAIR_CHECK_EN and WIDTH=12, write pos1=13 -> entry unchanged, cfg_err=1 until reset. Without the macro, the same write is stored, cfg_err=0, and that swap is a no-op.
